// File: rtl/cla_pipe_addsub.sv
// -----------------------------------------------------------------------------
// cla_pipe_addsub
//   Pipelined carry-lookahead adder/subtractor. The operands are cut into
//   G = WIDTH/BLOCK groups. Stage k resolves group k with a BLOCK-wide lookahead
//   and hands its carry-out to stage k+1 through a register. Each stage carries
//   the sum bits resolved so far, plus the still-unresolved upper slices of a and
//   b'. A valid/ready handshake on both sides gives full throughput; the whole
//   pipe stalls as a unit.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   in_valid / in_ready      input handshake
//   in_a, in_b               operands (WIDTH)
//   in_cin                   carry-in (add) / borrow-in (sub)
//   in_sub                   1 = a - b, 0 = a + b
//   in_tag                   sideband tag (TAG_W), returned with the result
//   out_valid / out_ready    output handshake
//   out_sum                  result (WIDTH)
//   out_cout                 carry out of bit WIDTH-1
//   out_ovf                  signed overflow
//   out_tag                  tag of this result
// -----------------------------------------------------------------------------

// One lookahead group: bit g/p cells feeding a flattened carry lookahead.
//   a_i, b_i  group operand slices (b already conditionally inverted)
//   c_i       carry into the group
//   sum_o     group sum bits
//   c_o       carry out of the group
//   c_msb_o   carry into the group's top bit (used for signed overflow)
module cla_group #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             c_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             c_o,
    output logic             c_msb_o
);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_i, written out as a
    // sum of products so every carry is two logic levels from g/p.
    always_comb begin
        logic acc;
        logic prod;
        acc  = 1'b0;
        prod = 1'b0;
        c    = '0;
        c[0] = c_i;
        for (int i = 0; i < BLOCK; i++) begin
            acc = c_i;
            for (int j = 0; j <= i; j++) acc = acc & p[j];
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int m = j + 1; m <= i; m++) prod = prod & p[m];
                acc = acc | prod;
            end
            c[i+1] = acc;
        end
    end

    assign sum_o   = p ^ c[BLOCK-1:0];
    assign c_o     = c[BLOCK];
    assign c_msb_o = c[BLOCK-1];
endmodule

module cla_pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);
    localparam int G = WIDTH / BLOCK;

    if ((WIDTH % BLOCK) != 0 || G < 1) begin : g_bad_params
        $error("cla_pipe_addsub: WIDTH (%0d) must be a non-zero multiple of BLOCK (%0d)",
               WIDTH, BLOCK);
    end

    logic             adv;
    logic [WIDTH-1:0] b_prep;
    logic             c0;
    logic [G-1:0]     vld_q;
    logic [G:0]       vld_pipe;

    // Subtract as a + ~b + 1; a borrow-in cancels the +1.
    assign b_prep = in_sub ? ~in_b : in_b;
    assign c0     = in_cin ^ in_sub;

    // vld_pipe[0] is the op being offered, vld_pipe[k+1] is stage k.
    assign vld_pipe  = {vld_q, in_valid};
    assign out_valid = vld_q[G-1];
    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;

    always_ff @(posedge clk) begin
        if (rst)      vld_q <= '0;
        else if (adv) vld_q <= vld_pipe[G-1:0];
    end

    genvar k;
    for (k = 0; k < G; k++) begin : g_stg
        localparam int LO  = k * BLOCK;           // first bit this stage resolves
        localparam int REM = WIDTH - LO - BLOCK;  // bits still unresolved after it

        logic [WIDTH-LO-1:0]   a_in;
        logic [WIDTH-LO-1:0]   b_in;
        logic                  cin_s;
        logic [TAG_W-1:0]      tag_in;
        logic [LO+BLOCK-1:0]   sum_d;
        logic [BLOCK-1:0]      gsum;
        logic                  gcout;
        logic                  gcmsb;
        logic                  load;

        logic [TAG_W-1:0]      tag_q;
        logic [LO+BLOCK-1:0]   sum_q;
        logic                  c_q;

        if (k == 0) begin : g_src
            assign a_in   = in_a;
            assign b_in   = b_prep;
            assign cin_s  = c0;
            assign tag_in = in_tag;
            assign sum_d  = gsum;
        end else begin : g_src
            assign a_in   = g_stg[k-1].g_rem.a_q;
            assign b_in   = g_stg[k-1].g_rem.b_q;
            assign cin_s  = g_stg[k-1].c_q;
            assign tag_in = g_stg[k-1].tag_q;
            assign sum_d  = {gsum, g_stg[k-1].sum_q};
        end

        cla_group #(.BLOCK(BLOCK)) u_grp (
            .a_i    (a_in[BLOCK-1:0]),
            .b_i    (b_in[BLOCK-1:0]),
            .c_i    (cin_s),
            .sum_o  (gsum),
            .c_o    (gcout),
            .c_msb_o(gcmsb)
        );

        // Data only moves with a real op, so bubbles leave the registers
        // untouched and a freshly reset pipe keeps presenting zeros.
        assign load = adv & vld_pipe[k];

        always_ff @(posedge clk) begin
            if (rst) begin
                tag_q <= '0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (load) begin
                tag_q <= tag_in;
                sum_q <= sum_d;
                c_q   <= gcout;
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_in[WIDTH-LO-1:BLOCK];
                    b_q <= b_in[WIDTH-LO-1:BLOCK];
                end
            end
        end else begin : g_last
            // Signed overflow: carry into the sign bit differs from carry out.
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (rst)       ovf_q <= 1'b0;
                else if (load) ovf_q <= gcout ^ gcmsb;
            end
        end
    end

    assign out_sum  = g_stg[G-1].sum_q;
    assign out_cout = g_stg[G-1].c_q;
    assign out_ovf  = g_stg[G-1].g_last.ovf_q;
    assign out_tag  = g_stg[G-1].tag_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_cin = 1'b0, in_sub = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic        out_cout, out_ovf;
    logic [3:0]  out_tag;

    // parameter-sweep instances share one stimulus bus
    logic        sw_valid = 1'b0;
    logic        sw_rdy = 1'b1;
    logic [63:0] sw_a = '0, sw_b = '0;
    logic        sw_cin = 1'b0, sw_sub = 1'b0;
    logic [3:0]  sw_tag = '0;
    logic        r8_ir, r8_v, r8_c, r8_o;  logic [7:0]  r8_s;  logic [3:0] r8_t;
    logic        r16_ir, r16_v, r16_c, r16_o; logic [15:0] r16_s; logic [3:0] r16_t;
    logic        r64_ir, r64_v, r64_c, r64_o; logic [63:0] r64_s; logic [3:0] r64_t;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(32), .BLOCK(8), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag));

    cla_pipe_addsub #(.WIDTH(8), .BLOCK(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8_ir),
        .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(sw_cin), .in_sub(sw_sub), .in_tag(sw_tag),
        .out_valid(r8_v), .out_ready(sw_rdy), .out_sum(r8_s),
        .out_cout(r8_c), .out_ovf(r8_o), .out_tag(r8_t));

    cla_pipe_addsub #(.WIDTH(16), .BLOCK(4), .TAG_W(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r16_ir),
        .in_a(sw_a[15:0]), .in_b(sw_b[15:0]), .in_cin(sw_cin), .in_sub(sw_sub), .in_tag(sw_tag),
        .out_valid(r16_v), .out_ready(sw_rdy), .out_sum(r16_s),
        .out_cout(r16_c), .out_ovf(r16_o), .out_tag(r16_t));

    cla_pipe_addsub #(.WIDTH(64), .BLOCK(8), .TAG_W(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r64_ir),
        .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub), .in_tag(sw_tag),
        .out_valid(r64_v), .out_ready(sw_rdy), .out_sum(r64_s),
        .out_cout(r64_c), .out_ovf(r64_o), .out_tag(r64_t));

    // Golden model: returns {ovf, cout, sum} for a w-bit operation.
    function automatic logic [65:0] gold(input int w, input logic [63:0] a, b,
                                         input logic cin, sub);
        logic [63:0] mask, aa, bb, s;
        logic [64:0] full;
        logic        co, ov;
        mask = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
        aa   = a & mask;
        bb   = (sub ? ~b : b) & mask;
        full = {1'b0, aa} + {1'b0, bb} + {64'h0, cin ^ sub};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {ov, co, s};
    endfunction

    // Drive one op into the 32-bit DUT with out_ready high and wait for it.
    task automatic run_op(input logic [31:0] a, b, input logic cin, sub, input logic [3:0] tag,
                          output logic [31:0] s, output logic co, ov, output logic [3:0] t,
                          output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = out_sum; co = out_cout; ov = out_ovf; t = out_tag;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_cout !== 1'b0 ||
            out_ovf !== 1'b0 || out_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b tag=%h, want all 0",
                     out_valid, out_sum, out_cout, out_ovf, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add;
        logic [31:0] s; logic co, ov; logic [3:0] t; int lat;
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 4'h3, s, co, ov, t, lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL add_latency: got %0d want 4", lat);
        end
        checks++;
        if (s !== 32'h0000_0100 || co !== 1'b0 || ov !== 1'b0 || t !== 4'h3) begin
            errors++;
            $display("FAIL add_result: got sum=%h c=%b o=%b tag=%h want 00000100 0 0 3", s, co, ov, t);
        end
    endtask

    task automatic test_carry_chain;
        logic [31:0] s; logic co, ov; logic [3:0] t; int lat;
        run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 4'h9, s, co, ov, t, lat);
        checks++;
        if (s !== 32'h0 || co !== 1'b1 || ov !== 1'b0 || t !== 4'h9) begin
            errors++;
            $display("FAIL carry_chain: got sum=%h c=%b o=%b tag=%h want 00000000 1 0 9", s, co, ov, t);
        end
    endtask

    task automatic test_sub;
        logic [31:0] s; logic co, ov; logic [3:0] t; int lat;
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 4'hA, s, co, ov, t, lat);
        checks++;
        if (s !== 32'h7FFF_FFFF || co !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("FAIL sub_ovf: got sum=%h c=%b o=%b want 7fffffff 1 1", s, co, ov);
        end
        run_op(32'h5, 32'h5, 1'b0, 1'b1, 4'hB, s, co, ov, t, lat);
        checks++;
        if (s !== 32'h0 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL sub_equal: got sum=%h c=%b o=%b want 00000000 1 0", s, co, ov);
        end
        run_op(32'h3, 32'h5, 1'b1, 1'b1, 4'hC, s, co, ov, t, lat);
        checks++;
        if (s !== 32'hFFFF_FFFD || co !== 1'b0 || ov !== 1'b0 || t !== 4'hC) begin
            errors++;
            $display("FAIL sub_borrow: got sum=%h c=%b o=%b tag=%h want fffffffd 0 0 c", s, co, ov, t);
        end
    endtask

    // Eight ops on consecutive cycles: results must come out on eight
    // consecutive cycles starting exactly 4 cycles after the first accept.
    task automatic test_back_to_back;
        exp_t q[$];
        exp_t e;
        logic [65:0] g;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (t < 8) begin
                in_valid = 1'b1;
                in_a = 32'h1111_1111 * t + 32'h0FFF_FFF0;
                in_b = 32'h7000_0000 + t;
                in_cin = t[0]; in_sub = t[1]; in_tag = 4'(t + 5);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_in_ready: cycle %0d got %b want 1", t, in_ready);
                end
                g = gold(32, {32'h0, in_a}, {32'h0, in_b}, in_cin, in_sub);
                e.sum = g[31:0]; e.cout = g[64]; e.ovf = g[65]; e.tag = in_tag;
                q.push_back(e);
            end
            checks++;
            if (out_valid !== (t >= 4 && t < 12)) begin
                errors++;
                $display("FAIL b2b_valid: cycle %0d got %b want %b", t, out_valid, (t >= 4 && t < 12));
            end
            if (out_valid && q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf || out_tag !== e.tag) begin
                    errors++;
                    $display("FAIL b2b_data: got %h/%b/%b/%h want %h/%b/%b/%h",
                             out_sum, out_cout, out_ovf, out_tag, e.sum, e.cout, e.ovf, e.tag);
                end
            end
        end
    endtask

    task automatic test_stream;
        exp_t q[$];
        exp_t e;
        logic [65:0] g;
        int n_in = 0, n_out = 0, cyc = 0;
        logic stalled = 1'b0;
        logic [31:0] s_sum; logic s_c, s_o; logic [3:0] s_t;
        s_sum = '0; s_c = 1'b0; s_o = 1'b0; s_t = '0;
        while (n_out < 100 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_sum !== s_sum || out_cout !== s_c ||
                    out_ovf !== s_o || out_tag !== s_t) begin
                    errors++;
                    $display("FAIL stream_stall_hold: got v=%b %h/%b/%b/%h want 1 %h/%b/%b/%h",
                             out_valid, out_sum, out_cout, out_ovf, out_tag, s_sum, s_c, s_o, s_t);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (n_in < 100 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_a = $urandom; in_b = $urandom;
                in_cin = 1'($urandom_range(0, 1)); in_sub = 1'($urandom_range(0, 1));
                in_tag = n_in[3:0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra: result with tag %h and nothing pending", out_tag);
                end else begin
                    e = q.pop_front();
                    if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf || out_tag !== e.tag) begin
                        errors++;
                        $display("FAIL stream_data #%0d: got %h/%b/%b/%h want %h/%b/%b/%h", n_out,
                                 out_sum, out_cout, out_ovf, out_tag, e.sum, e.cout, e.ovf, e.tag);
                    end
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                g = gold(32, {32'h0, in_a}, {32'h0, in_b}, in_cin, in_sub);
                e.sum = g[31:0]; e.cout = g[64]; e.ovf = g[65]; e.tag = in_tag;
                q.push_back(e);
                n_in++;
            end
            stalled = out_valid && !out_ready;
            s_sum = out_sum; s_c = out_cout; s_o = out_ovf; s_t = out_tag;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (n_out != 100 || n_in != 100) begin
            errors++; $display("FAIL stream_count: in=%0d out=%0d want 100/100", n_in, n_out);
        end
    endtask

    task automatic test_reset_midflight;
        int seen = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 32'hFFFF_0000 + t; in_b = 32'h1234_5678;
            in_cin = 1'b1; in_sub = 1'b0; in_tag = 4'(t + 1);
            if (t == 2) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_in_ready: got %b want 1", in_ready);
        end
        for (int t = 0; t < 8; t++) begin
            if (out_valid !== 1'b0 || out_sum !== 32'h0 || out_cout !== 1'b0 ||
                out_ovf !== 1'b0 || out_tag !== 4'h0) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL midreset_flush: %0d cycles with nonzero outputs, want 0", seen);
        end
    endtask

    task automatic test_sweep;
        logic [65:0] g8, g16, g64;
        int l8, l16, l64;
        logic [7:0] s8; logic [15:0] s16; logic [63:0] s64;
        logic [2:0] f8, f16, f64;
        logic [3:0] t8, t16, t64;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            sw_valid = 1'b1;
            sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
            if (n == 0) begin sw_a = '1; sw_b = '0; end   // full-length carry chain
            sw_cin = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
            if (n == 0) begin sw_cin = 1'b1; sw_sub = 1'b0; end
            sw_tag = 4'(n + 7);
            g8  = gold(8,  sw_a, sw_b, sw_cin, sw_sub);
            g16 = gold(16, sw_a, sw_b, sw_cin, sw_sub);
            g64 = gold(64, sw_a, sw_b, sw_cin, sw_sub);
            l8 = 0; l16 = 0; l64 = 0;
            s8 = '0; s16 = '0; s64 = '0; f8 = '0; f16 = '0; f64 = '0; t8 = '0; t16 = '0; t64 = '0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                sw_valid = 1'b0;
                if (r8_v && l8 == 0)   begin l8 = c;  s8 = r8_s;   f8 = {r8_o, r8_c, 1'b1};   t8 = r8_t;  end
                if (r16_v && l16 == 0) begin l16 = c; s16 = r16_s; f16 = {r16_o, r16_c, 1'b1}; t16 = r16_t; end
                if (r64_v && l64 == 0) begin l64 = c; s64 = r64_s; f64 = {r64_o, r64_c, 1'b1}; t64 = r64_t; end
            end
            checks++;
            if (l8 != 1 || l16 != 4 || l64 != 8) begin
                errors++; $display("FAIL sweep_latency #%0d: got %0d/%0d/%0d want 1/4/8", n, l8, l16, l64);
            end
            checks++;
            if (s8 !== g8[7:0] || f8 !== {g8[65:64], 1'b1} || t8 !== 4'(n + 7)) begin
                errors++; $display("FAIL sweep_w8 #%0d: got %h ovf/cout=%b want %h %b", n, s8, f8[2:1], g8[7:0], g8[65:64]);
            end
            checks++;
            if (s16 !== g16[15:0] || f16 !== {g16[65:64], 1'b1} || t16 !== 4'(n + 7)) begin
                errors++; $display("FAIL sweep_w16 #%0d: got %h ovf/cout=%b want %h %b", n, s16, f16[2:1], g16[15:0], g16[65:64]);
            end
            checks++;
            if (s64 !== g64[63:0] || f64 !== {g64[65:64], 1'b1} || t64 !== 4'(n + 7)) begin
                errors++; $display("FAIL sweep_w64 #%0d: got %h ovf/cout=%b want %h %b", n, s64, f64[2:1], g64[63:0], g64[65:64]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_sub();
        test_back_to_back();
        test_stream();
        test_reset_midflight();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
